alu_op_sequencer: RTL

Initiator side of the ALU32 operand/result interface. It accepts operation requests over a valid/ready handshake and drives a, b and ALUop into ALU32. It pulses the ALU's reset to restart the multi-cycle mod unit, waits the required latency, captures the result and returns it over a valid/ready response handshake. It sits between the datapath control and ALU32, so no upstream logic has to know per-op latency.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/op_latency_counter.sv | 28 ++
 rtl/alu_op_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ALU32 opcode encodings and the sequencer state type, shared by the
// sequencer and anything else that talks to ALU32.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MOD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MOD_START,
    MOD_WAIT,
    RESP
  } seq_state_t;

endpackage

// File: rtl/op_latency_counter.sv
// Down-counter timing the mod unit latency; load has priority over decrement
// and the count parks at zero.
module op_latency_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Runs one ALU32 operation at a time: drives operands, restarts the mod unit
// when needed, waits out its latency and returns the captured result.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   IDLE      | ready for a request; operands registered on acceptance
//   EXEC      | single-cycle op settling; result captured on exit
//   MOD_START | alu_reset pulse, latency counter loaded
//   MOD_WAIT  | counting down mod latency; result captured at terminal count
//   RESP      | response presented until rsp_ready
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MOD_LATENCY = 34,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_reset,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [CNT_W-1:0] MOD_LOAD = CNT_W'(MOD_LATENCY - 1);

  seq_state_t state, state_next;
  logic       accept;
  logic       capture;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;
  logic       mod_by_zero;

  assign mod_by_zero = (req_op == OP_MOD) && (req_b == '0);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_op != OP_MOD) state_next = EXEC;
          else if (mod_by_zero) state_next = RESP;
          else                  state_next = MOD_START;
        end
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      MOD_START: begin
        cnt_load   = 1'b1;
        state_next = MOD_WAIT;
      end
      MOD_WAIT: begin
        if (cnt_zero) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        alu_a      <= req_a;
        alu_b      <= req_b;
        alu_op     <= req_op;
        rsp_result <= '0;
        rsp_err    <= mod_by_zero;
      end else if (capture) begin
        rsp_result <= alu_result;
        rsp_err    <= 1'b0;
      end
    end
  end

  // Ready is masked while reset is held so every output reads 0 in reset.
  assign req_ready = (state == IDLE) && !reset;
  assign rsp_valid = (state == RESP);
  assign alu_reset = (state == MOD_START);

  op_latency_counter #(
    .CNT_W(CNT_W)
  ) u_latency (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .dec       (cnt_dec),
    .load_value(MOD_LOAD),
    .zero      (cnt_zero)
  );

endmodule
